// File: rtl/ins_cache_pkg.sv
// Shared types and geometry helpers for the N-way instruction cache.
// Address field widths are derived from the cache geometry parameters.
package ins_cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StRefill
  } state_e;

  function automatic int unsigned calc_off_w(int unsigned words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int unsigned calc_idx_w(int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned calc_tag_w(int unsigned addr_w, int unsigned words_per_line,
                                             int unsigned sets);
    return addr_w - calc_idx_w(sets) - calc_off_w(words_per_line);
  endfunction

  // Zero-width fields still need a 1-bit carrier signal.
  function automatic int unsigned clamp_w(int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way choice for one set: lowest invalid way, else the round-robin pointer.
module icache_victim_sel #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned RR_W = 1
) (
  input  logic [WAYS-1:0] valid,
  input  logic [RR_W-1:0] rr_ptr,
  output logic [RR_W-1:0] victim
);

  logic found;

  always_comb begin
    victim = rr_ptr;
    found  = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!valid[w] && !found) begin
        victim = RR_W'(w);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ins_cache_nway.sv
// N-way set-associative instruction cache with single-cycle lookup, round-robin
// replacement, synchronous flush and saturating hit/miss counters.
module ins_cache_nway
  import ins_cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned SETS           = 8,
  parameter int unsigned WAYS           = 2
) (
  input  logic                                            CLK,
  input  logic                                            RESET,
  input  logic                                            cpu_req,
  input  logic [ADDR_W-1:0]                               PC,
  input  logic                                            flush,
  output logic [31:0]                                     instruction,
  output logic                                            icache_busy,
  output logic                                            imem_read,
  output logic [ADDR_W-calc_off_w(WORDS_PER_LINE)-1:0]    imem_address,
  input  logic [32*WORDS_PER_LINE-1:0]                    imem_readdata,
  input  logic                                            imem_busy,
  output logic [31:0]                                     hit_count,
  output logic [31:0]                                     miss_count
);

  localparam int unsigned OFF_W  = calc_off_w(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = calc_idx_w(SETS);
  localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, WORDS_PER_LINE, SETS);
  localparam int unsigned LINE_W = 32 * WORDS_PER_LINE;
  localparam int unsigned LA_W   = ADDR_W - OFF_W;
  localparam int unsigned IDX_WS = clamp_w(IDX_W);
  localparam int unsigned WSEL_W = clamp_w($clog2(WORDS_PER_LINE));
  localparam int unsigned RR_W   = clamp_w($clog2(WAYS));

  state_e state_q;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [RR_W-1:0]   rr_q    [SETS];

  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_WS-1:0] req_idx_q;
  logic [LINE_W-1:0] line_q;
  logic              flush_pending_q;

  logic [LA_W-1:0]   pc_line;
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_WS-1:0] pc_idx;
  logic [WSEL_W-1:0] word_sel;
  logic              unused_pc;

  assign pc_line   = PC[ADDR_W-1:OFF_W];
  assign pc_tag    = pc_line[LA_W-1:IDX_W];
  assign unused_pc = ^PC[1:0];

  if (SETS > 1) begin : g_idx
    assign pc_idx = pc_line[IDX_WS-1:0];
  end else begin : g_idx_single
    assign pc_idx = '0;
  end

  if (WORDS_PER_LINE > 1) begin : g_wsel
    assign word_sel = PC[OFF_W-1:2];
  end else begin : g_wsel_single
    assign word_sel = '0;
  end

  // Lookup across all ways of the indexed set; at most one way can match.
  logic [WAYS-1:0]   way_hit;
  logic [LINE_W-1:0] hit_line;
  logic              hit;

  always_comb begin
    hit_line = '0;
    way_hit  = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      way_hit[w] = valid_q[w][pc_idx] && (tag_q[w][pc_idx] == pc_tag);
      hit_line   = hit_line | (data_q[w][pc_idx] & {LINE_W{way_hit[w]}});
    end
  end

  assign hit = |way_hit;

  always_comb begin
    instruction = '0;
    for (int wd = 0; wd < int'(WORDS_PER_LINE); wd++) begin
      if (word_sel == WSEL_W'(wd)) begin
        instruction = hit_line[wd*32 +: 32];
      end
    end
  end

  assign icache_busy = cpu_req && ((state_q != StIdle) || !hit);

  logic [SETS*RR_W-1:0] victim_flat;
  logic [RR_W-1:0]      refill_victim;

  for (genvar s = 0; s < int'(SETS); s++) begin : g_set
    logic [WAYS-1:0] set_valid;

    always_comb begin
      set_valid = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
        set_valid[w] = valid_q[w][s];
      end
    end

    icache_victim_sel #(
      .WAYS (WAYS),
      .RR_W (RR_W)
    ) u_victim_sel (
      .valid  (set_valid),
      .rr_ptr (rr_q[s]),
      .victim (victim_flat[s*RR_W +: RR_W])
    );
  end

  assign refill_victim = victim_flat[req_idx_q*RR_W +: RR_W];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= StIdle;
      imem_read       <= 1'b0;
      imem_address    <= '0;
      req_tag_q       <= '0;
      req_idx_q       <= '0;
      line_q          <= '0;
      flush_pending_q <= 1'b0;
      hit_count       <= '0;
      miss_count      <= '0;
      for (int w = 0; w < int'(WAYS); w++) valid_q[w] <= '0;
      for (int s = 0; s < int'(SETS); s++) rr_q[s] <= '0;
    end else begin
      if (state_q == StIdle && cpu_req && hit && hit_count != '1) begin
        hit_count <= hit_count + 32'd1;
      end
      unique case (state_q)
        StIdle: begin
          flush_pending_q <= 1'b0;
          if (cpu_req && !hit && !flush) begin
            state_q      <= StMemRead;
            req_tag_q    <= pc_tag;
            req_idx_q    <= pc_idx;
            imem_read    <= 1'b1;
            imem_address <= pc_line;
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
          end
        end
        StMemRead: begin
          if (flush) flush_pending_q <= 1'b1;
          if (!imem_busy) begin
            line_q    <= imem_readdata;
            imem_read <= 1'b0;
            state_q   <= StRefill;
          end
        end
        StRefill: begin
          // A flush that overlapped this miss leaves the new line invalid.
          valid_q[refill_victim][req_idx_q] <= !flush_pending_q && !flush;
          if (WAYS > 1) rr_q[req_idx_q] <= rr_q[req_idx_q] + RR_W'(1);
          flush_pending_q <= 1'b0;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (flush) begin
        for (int w = 0; w < int'(WAYS); w++) valid_q[w] <= '0;
      end
    end
  end

  // Payload arrays need no reset; valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (state_q == StRefill) begin
      data_q[refill_victim][req_idx_q] <= line_q;
      tag_q[refill_victim][req_idx_q]  <= req_tag_q;
    end
  end

endmodule

// File: tb/tb_ins_cache_nway.sv
// Directed bench for ins_cache_nway plus a random-PC sweep over two other geometries.
`timescale 1ns / 1ps
module tb_ins_cache_nway;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         cpu_req = 1'b0;
  logic [31:0]  PC = '0;
  logic         flush = 1'b0;

  logic [31:0]  instruction, instruction_b, instruction_c;
  logic         icache_busy, icache_busy_b, icache_busy_c;
  logic         imem_read, imem_read_b, imem_read_c;
  logic [27:0]  imem_address;
  logic [26:0]  imem_address_b;
  logic [29:0]  imem_address_c;
  logic [127:0] imem_readdata = '0;
  logic [255:0] imem_readdata_b = '0;
  logic [31:0]  imem_readdata_c = '0;
  logic         imem_busy = 1'b1, imem_busy_b = 1'b1, imem_busy_c = 1'b1;
  logic [31:0]  hit_count, miss_count, hit_count_b, miss_count_b, hit_count_c, miss_count_c;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int mem_cnt = 0, mem_cnt_b = 0, mem_cnt_c = 0;

  always #5 CLK = ~CLK;

  ins_cache_nway dut (
    .CLK (CLK), .RESET (RESET), .cpu_req (cpu_req), .PC (PC), .flush (flush),
    .instruction (instruction), .icache_busy (icache_busy), .imem_read (imem_read),
    .imem_address (imem_address), .imem_readdata (imem_readdata), .imem_busy (imem_busy),
    .hit_count (hit_count), .miss_count (miss_count)
  );

  ins_cache_nway #(.WAYS (4), .WORDS_PER_LINE (8), .SETS (16)) dut_b (
    .CLK (CLK), .RESET (RESET), .cpu_req (cpu_req), .PC (PC), .flush (flush),
    .instruction (instruction_b), .icache_busy (icache_busy_b), .imem_read (imem_read_b),
    .imem_address (imem_address_b), .imem_readdata (imem_readdata_b),
    .imem_busy (imem_busy_b), .hit_count (hit_count_b), .miss_count (miss_count_b)
  );

  ins_cache_nway #(.WAYS (1), .WORDS_PER_LINE (1), .SETS (16)) dut_c (
    .CLK (CLK), .RESET (RESET), .cpu_req (cpu_req), .PC (PC), .flush (flush),
    .instruction (instruction_c), .icache_busy (icache_busy_c), .imem_read (imem_read_c),
    .imem_address (imem_address_c), .imem_readdata (imem_readdata_c),
    .imem_busy (imem_busy_c), .hit_count (hit_count_c), .miss_count (miss_count_c)
  );

  // Reference memory: word-addressed contents, independent of line size.
  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    case (wa)
      32'd0:   return 32'h0000_0013;
      32'd1:   return 32'hDEAD_BEEF;
      32'd2:   return 32'h1111_0000;
      32'd3:   return 32'h3333_2222;
      default: return (wa * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Memory responders: busy for (latency-1) cycles of a read, then data valid.
  always @(negedge CLK) begin
    if (imem_read) begin
      for (int w = 0; w < 4; w++)
        imem_readdata[w*32 +: 32] = mem_word(32'({imem_address, 2'b00}) + 32'(w));
      imem_busy = (mem_cnt + 1 < mem_lat);
      mem_cnt++;
    end else begin
      mem_cnt   = 0;
      imem_busy = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (imem_read_b) begin
      for (int w = 0; w < 8; w++)
        imem_readdata_b[w*32 +: 32] = mem_word(32'({imem_address_b, 3'b000}) + 32'(w));
      imem_busy_b = (mem_cnt_b + 1 < 2);
      mem_cnt_b++;
    end else begin
      mem_cnt_b   = 0;
      imem_busy_b = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (imem_read_c) begin
      imem_readdata_c = mem_word(32'(imem_address_c));
      imem_busy_c     = (mem_cnt_c + 1 < 4);
      mem_cnt_c++;
    end else begin
      mem_cnt_c   = 0;
      imem_busy_c = 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; cpu_req = 1'b0; flush = 1'b0; PC = '0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Request addr and wait until the main cache stops stalling; cyc = stall cycles.
  task automatic fetch(input logic [31:0] addr, output int cyc);
    cpu_req = 1'b1; PC = addr; #1;
    cyc = 0;
    while (icache_busy && cyc < 60) begin
      @(negedge CLK); #1;
      cyc++;
    end
    checks++;
    if (icache_busy) begin
      errors++;
      $display("FAIL fetch_timeout addr=%h: still busy after %0d cycles, required not busy", addr, cyc);
    end
  endtask

  task automatic test_reset();
    do_reset(); #1;
    checks++; if (icache_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", icache_busy); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instruction); end
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL rst_imem_read: got %b want 0", imem_read); end
    checks++; if (imem_address !== 28'h0) begin errors++; $display("FAIL rst_imem_addr: got %h want 0", imem_address); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++; $display("FAIL rst_counters: got hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
    cpu_req = 1'b1; PC = 32'h0; #1;
    checks++; if (icache_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_req: got %b want 1", icache_busy); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instr_req: got %h want 0", instruction); end
    cpu_req = 1'b0;
  endtask

  task automatic test_cold_miss();
    int cyc;
    do_reset();
    mem_lat = 3;
    fetch(32'h0, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL cold_stall: got %0d cycles want 5", cyc); end
    checks++; if (instruction !== 32'h0000_0013) begin errors++; $display("FAIL cold_instr: got %h want 00000013", instruction); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_count); end
    checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL cold_hit_cnt0: got %0d want 0", hit_count); end
    fetch(32'h4, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL hit_stall: got %0d cycles want 0", cyc); end
    checks++; if (instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_instr: got %h want deadbeef", instruction); end
    @(negedge CLK); #1;
    checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL hit_cnt: got %0d want 1", hit_count); end
    cpu_req = 1'b0;
  endtask

  task automatic test_conflict();
    int cyc;
    do_reset();
    mem_lat = 1;
    fetch(32'h000, cyc);
    fetch(32'h080, cyc);
    fetch(32'h100, cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL conf_miss_100: got %0d cycles want 3", cyc); end
    fetch(32'h080, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL conf_hit_080: got %0d cycles want 0", cyc); end
    checks++; if (instruction !== mem_word(32'h20)) begin
      errors++; $display("FAIL conf_instr_080: got %h want %h", instruction, mem_word(32'h20));
    end
    fetch(32'h000, cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL conf_evicted_000: got %0d cycles want 3", cyc); end
    checks++; if (instruction !== 32'h0000_0013) begin errors++; $display("FAIL conf_instr_000: got %h want 00000013", instruction); end
    // Round-robin: the refill of 0x000 must have displaced 0x080, not 0x100.
    fetch(32'h100, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL rr_hit_100: got %0d cycles want 0", cyc); end
    fetch(32'h080, cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL rr_miss_080: got %0d cycles want 3", cyc); end
    checks++; if (miss_count !== 32'd5) begin errors++; $display("FAIL conf_miss_cnt: got %0d want 5", miss_count); end
    cpu_req = 1'b0;
  endtask

  task automatic test_flush();
    int cyc;
    do_reset();
    mem_lat = 1;
    cpu_req = 1'b1; PC = 32'h200; flush = 1'b1;
    @(negedge CLK); #1;
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL flush_prio: imem_read got %b want 0", imem_read); end
    flush = 1'b0;
    fetch(32'h0, cyc);
    cpu_req = 1'b0; flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0; cpu_req = 1'b1; PC = 32'h0; #1;
    checks++; if (icache_busy !== 1'b1) begin errors++; $display("FAIL flush_inval: busy got %b want 1", icache_busy); end
    fetch(32'h0, cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL flush_remiss: got %0d cycles want 3", cyc); end
    // Flush while the miss on 0x010 sits in MEM_READ forces a second miss.
    PC = 32'h010; #1;
    cyc = 0;
    while (icache_busy && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      flush = (cyc == 1);
      #1;
    end
    checks++; if (cyc != 6) begin errors++; $display("FAIL flush_mr_stall: got %0d cycles want 6", cyc); end
    checks++; if (instruction !== mem_word(32'h4)) begin
      errors++; $display("FAIL flush_mr_instr: got %h want %h", instruction, mem_word(32'h4));
    end
    fetch(32'h0, cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL flush_mr_clear: got %0d cycles want 3", cyc); end
    checks++; if (miss_count !== 32'd5) begin errors++; $display("FAIL flush_miss_cnt: got %0d want 5", miss_count); end
    cpu_req = 1'b0;
  endtask

  task automatic test_pc_change();
    int cyc;
    do_reset();
    mem_lat = 3;
    cpu_req = 1'b1; PC = 32'h010;
    @(negedge CLK); #1;
    checks++; if (imem_read !== 1'b1 || imem_address !== 28'h1) begin
      errors++; $display("FAIL pcchg_req: got read=%b addr=%h want 1/1", imem_read, imem_address);
    end
    PC = 32'h020;
    @(negedge CLK); #1;
    checks++; if (imem_read !== 1'b1 || imem_address !== 28'h1) begin
      errors++; $display("FAIL pcchg_hold: got read=%b addr=%h want 1/1", imem_read, imem_address);
    end
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (imem_read !== 1'b0 || icache_busy !== 1'b1) begin
      errors++; $display("FAIL pcchg_refill: got read=%b busy=%b want 0/1", imem_read, icache_busy);
    end
    @(negedge CLK); #1;
    checks++; if (icache_busy !== 1'b1 || imem_read !== 1'b0 || miss_count !== 32'd1) begin
      errors++; $display("FAIL pcchg_newpc: got busy=%b read=%b miss=%0d want 1/0/1", icache_busy, imem_read, miss_count);
    end
    fetch(32'h020, cyc);
    checks++; if (cyc != 5 || instruction !== mem_word(32'h8)) begin
      errors++; $display("FAIL pcchg_020: got %0d cycles instr=%h want 5/%h", cyc, instruction, mem_word(32'h8));
    end
    fetch(32'h010, cyc);
    checks++; if (cyc != 0 || instruction !== mem_word(32'h4)) begin
      errors++; $display("FAIL pcchg_010: got %0d cycles instr=%h want 0/%h", cyc, instruction, mem_word(32'h4));
    end
    checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL pcchg_miss_cnt: got %0d want 2", miss_count); end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    mem_lat = 1;
    fetch(32'h0, cyc);
    @(negedge CLK); #1;
    checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL rstmid_pre_hit: got %0d want 1", hit_count); end
    mem_lat = 5;
    PC = 32'h040;
    @(negedge CLK); #1;
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL rstmid_mr: imem_read got %b want 1", imem_read); end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; cpu_req = 1'b0; #1;
    checks++; if (imem_read !== 1'b0 || imem_address !== 28'h0) begin
      errors++; $display("FAIL rstmid_read: got read=%b addr=%h want 0/0", imem_read, imem_address);
    end
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++; $display("FAIL rstmid_cnt: got hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
    checks++; if (icache_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy got %b want 0", icache_busy); end
    cpu_req = 1'b1; PC = 32'h0; #1;
    checks++; if (icache_busy !== 1'b1) begin errors++; $display("FAIL rstmid_inval: busy got %b want 1", icache_busy); end
    mem_lat = 1;
    fetch(32'h0, cyc);
    checks++; if (cyc != 3 || instruction !== 32'h0000_0013) begin
      errors++; $display("FAIL rstmid_refetch: got %0d cycles instr=%h want 3/00000013", cyc, instruction);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_param_sweep();
    logic [31:0] pc;
    logic [31:0] exp;
    bit da, db, dc;
    int cyc;
    do_reset();
    mem_lat = 2;
    cpu_req = 1'b1;
    for (int n = 0; n < 40; n++) begin
      pc = 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFC;
      exp = mem_word(pc >> 2);
      PC = pc; #1;
      da = 0; db = 0; dc = 0; cyc = 0;
      while (cyc < 100) begin
        if (!da && !icache_busy) begin
          da = 1; checks++;
          if (instruction !== exp) begin errors++; $display("FAIL sweep_a pc=%h: got %h want %h", pc, instruction, exp); end
        end
        if (!db && !icache_busy_b) begin
          db = 1; checks++;
          if (instruction_b !== exp) begin errors++; $display("FAIL sweep_b pc=%h: got %h want %h", pc, instruction_b, exp); end
        end
        if (!dc && !icache_busy_c) begin
          dc = 1; checks++;
          if (instruction_c !== exp) begin errors++; $display("FAIL sweep_c pc=%h: got %h want %h", pc, instruction_c, exp); end
        end
        if (da && db && dc) break;
        @(negedge CLK); #1;
        cyc++;
      end
      checks++;
      if (!(da && db && dc)) begin
        errors++; $display("FAIL sweep_timeout pc=%h: done a/b/c=%b%b%b want 111", pc, da, db, dc);
      end
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_flush();
    test_pc_change();
    test_reset_mid();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_cache_nway.md
# ins_cache_nway

Parametrised N-way set-associative instruction cache, next generation of the direct-mapped single-cycle-lookup cache. Sits between the CPU fetch stage and the instruction memory. Generalised in line size, set count, associativity and address width. Adds round-robin replacement, synchronous flush, an explicit request qualifier, and hit/miss performance counters.

## Interface
- ADDR_W, 32: byte address width of PC.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥1.
- SETS, 8: number of sets; power of two, ≥1.
- WAYS, 2: associativity; power of two, ≥1 (1 = direct mapped).
- Derived: OFF_W = log2(WORDS_PER_LINE)+2, IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W, LINE_W = 32*WORDS_PER_LINE.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch request valid; PC is ignored when low.
- PC  in  ADDR_W  byte address; bits [1:0] are ignored.
- flush  in  1  invalidate all lines.
- instruction  out  32  fetched word; valid when cpu_req && !icache_busy.
- icache_busy  out  1  CPU must stall.
- imem_read  out  1  memory read request.
- imem_address  out  ADDR_W-OFF_W  line address (PC[ADDR_W-1:OFF_W]).
- imem_readdata  in  LINE_W  line data; word 0 in bits [31:0].
- imem_busy  in  1  memory busy; data valid in the cycle it is low while imem_read=1.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.

## Operation
- Address split: offset = PC[OFF_W-1:0], index = PC[OFF_W+IDX_W-1:OFF_W], tag = upper TAG_W bits.
- Lookup is combinational across all ways of the indexed set. hit = any way with valid && tag match. At most one way matches.
- instruction = word PC[OFF_W-1:2] of the hitting line. When there is no hit, it is 0.
- icache_busy = cpu_req && (state != IDLE || !hit). It is 0 when cpu_req = 0.
- FSM states: IDLE, MEM_READ, REFILL.
  - IDLE → MEM_READ when cpu_req && !hit && !flush. Latches tag and index into req_addr, increments miss_count.
  - MEM_READ: imem_read = 1 and imem_address = latched line address, both held stable. When imem_busy = 0, capture imem_readdata → REFILL.
  - REFILL: write the line, tag and valid into the victim way, advance that set's round-robin pointer → IDLE.
- Victim selection: the lowest-index invalid way. If all ways are valid, the per-set round-robin pointer (log2(WAYS) bits) chooses the victim. The pointer advances by 1 modulo WAYS on every refill into the set.
- hit_count increments in each cycle with state == IDLE && cpu_req && hit. Both counters saturate at 0xFFFFFFFF.
- PC changes during a miss: the refill uses the latched address. The new PC is looked up on return to IDLE.
- flush: all valid bits clear at the next edge. If flush is seen in MEM_READ or REFILL, a flush_pending flag is set. The refill still completes the memory handshake but writes valid = 0. flush_pending clears on entry to IDLE.
- flush in IDLE takes precedence over starting a miss.

## Timing
- Reset values: state IDLE, imem_read 0, imem_address 0, all valid bits 0, all RR pointers 0, counters 0, flush_pending 0. icache_busy = cpu_req; instruction = 0.
- RESET in any state aborts the FSM in the same edge. Memory data arriving afterwards is ignored.
- Hit latency: 0 cycles (same cycle as request).
- Miss penalty: 1 (IDLE→MEM_READ) + memory cycles until imem_busy is low + 1 (REFILL). The hit is visible in the first IDLE cycle after REFILL.
- imem_read goes low in the cycle after data capture and is never asserted in IDLE or REFILL.

## Structure
- Package ins_cache_pkg: FSM state enum, and functions computing OFF_W, IDX_W and TAG_W from the parameters.
- Sub-module icache_victim_sel (per set): takes the valid vector and RR pointer, returns the victim way. It is purely combinational; the pointer registers live in the top level.
- Data, tag and valid arrays use flat registers indexed [way][set]. No memory macro.

## Test plan
- Cold miss: RESET, then cpu_req=1, PC=0x0, memory busy 3 cycles returning 0x33332222_11110000_DEADBEEF_00000013 → busy for 5 cycles, instruction=0x00000013, miss_count=1. Then PC=0x4 → 0xDEADBEEF with zero stall, hit_count increments.
- 2-way conflict: fill 0x000 and 0x080 (set 0), then 0x100 evicts way 0 → 0x080 hits, 0x000 misses.
- Flush: with 0x000 cached, pulse flush → next fetch of 0x000 misses. A flush during MEM_READ leaves the refilled line invalid and triggers a re-miss.
- PC change mid-miss: PC switches from 0x010 to 0x020 in MEM_READ → imem_address stays 0x1, line 0x010 is installed, then 0x020 misses.
- RESET during MEM_READ → imem_read=0 next cycle, all lines invalid, counters 0.
- Parameter sweep WAYS=1/4, WORDS_PER_LINE=1/8, SETS=16 → random PC stream matches the reference memory model with no X on instruction.
